// File: rtl/pkt_dispatch_pkg.sv
// Shared definitions for the packet dispatcher: mode codes, FSM states and
// the ctrl-word decode used for header/EOP detection.
package pkt_dispatch_pkg;

   localparam logic [1:0] MODE_BCAST = 2'd0;
   localparam logic [1:0] MODE_RR    = 2'd1;
   localparam logic [1:0] MODE_FIXED = 2'd2;

   localparam int unsigned CTRL_MAX_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_BODY
   } state_t;

   // Non-zero ctrl marks a module header (in HDR) or the EOP word (in BODY).
   function automatic logic ctrl_marked(input logic [CTRL_MAX_W-1:0] ctrl);
      return |ctrl;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first requester found searching
// upward (modulo N) from ptr+1.
module rr_pick #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic         valid
);

   always_comb begin
      int unsigned idx;
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!valid && req[idx[W-1:0]]) begin
            grant[idx[W-1:0]] = 1'b1;
            valid             = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pkt_dispatcher.sv
// N-channel packet dispatcher (broadcast / round-robin / fixed-select) with
// per-channel backpressure. Optional per-channel packet counters: PKT_DISPATCH_CNT_EN.
module pkt_dispatcher
   import pkt_dispatch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned CH_W       = $clog2(NUM_CH)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic [CTRL_WIDTH-1:0]          in_ctrl,
   input  logic                           in_wr,
   output logic                           in_rdy,
   input  logic [1:0]                     mode,
   input  logic [CH_W-1:0]                fixed_sel,
   input  logic [NUM_CH-1:0]              ch_enable,
   input  logic [NUM_CH-1:0]              ch_almfull,
   input  logic [NUM_CH-1:0]              ch_stall,
   output logic [NUM_CH*DATA_WIDTH-1:0]   out_data,
   output logic [NUM_CH*CTRL_WIDTH-1:0]   out_ctrl,
   output logic [NUM_CH-1:0]              out_wr,
   output logic                           busy
`ifdef PKT_DISPATCH_CNT_EN
   ,
   output logic [NUM_CH*32-1:0]           ch_pkt_cnt
`endif
);

   state_t              state, state_nx;
   logic [NUM_CH-1:0]   tgt_mask;
   logic [NUM_CH-1:0]   ch_flow, ch_ready;
   logic [NUM_CH-1:0]   cand_mask, rr_grant, wr_mask;
   logic [CH_W-1:0]     rr_ptr, rr_idx;
   logic                rr_valid, cand_ok, marked, fwd, sop, rdy_c;

   assign ch_flow  = ~ch_almfull & ~ch_stall;
   assign ch_ready = ch_enable & ch_flow;
   assign marked   = ctrl_marked(CTRL_MAX_W'(in_ctrl));

   rr_pick #(.N(NUM_CH), .W(CH_W)) u_rr_pick (
      .req   (ch_ready),
      .ptr   (rr_ptr),
      .grant (rr_grant),
      .valid (rr_valid)
   );

   always_comb begin
      cand_mask = '0;
      cand_ok   = 1'b0;
      case (mode)
         MODE_RR: begin
            cand_mask = rr_grant;
            cand_ok   = rr_valid;
         end
         MODE_FIXED: begin
            if (32'(fixed_sel) < NUM_CH && ch_enable[fixed_sel]) begin
               cand_mask[fixed_sel] = 1'b1;
               cand_ok              = ch_ready[fixed_sel];
            end
         end
         default: begin
            cand_mask = ch_enable;
            cand_ok   = (ch_enable != '0) && (ch_ready == ch_enable);
         end
      endcase
   end

   always_comb begin
      rr_idx = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         if (rr_grant[i]) rr_idx = CH_W'(i);
   end

   // Mid-packet only flow control over the latched mask matters; enable is
   // deliberately ignored so a channel disabled mid-packet still drains it.
   assign wr_mask = (state == ST_IDLE) ? cand_mask : tgt_mask;
   assign sop     = (state == ST_IDLE) && in_wr && (cand_mask != '0);
   assign fwd     = in_wr && ((state != ST_IDLE) || (cand_mask != '0));

   always_comb begin
      state_nx = state;
      rdy_c    = 1'b0;
      case (state)
         ST_IDLE: begin
            rdy_c = cand_ok;
            if (sop) state_nx = marked ? ST_HDR : ST_BODY;
         end
         ST_HDR: begin
            rdy_c = &(ch_flow | ~tgt_mask);
            if (in_wr && !marked) state_nx = ST_BODY;
         end
         ST_BODY: begin
            rdy_c = &(ch_flow | ~tgt_mask);
            if (in_wr && marked) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign in_rdy = ~reset & rdy_c;
   assign busy   = (state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         tgt_mask <= '0;
         rr_ptr   <= CH_W'(NUM_CH - 1);
      end else begin
         state <= state_nx;
         if (sop) begin
            tgt_mask <= cand_mask;
            if (mode == MODE_RR) rr_ptr <= rr_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_wr   <= '0;
         out_data <= '0;
         out_ctrl <= '0;
      end else begin
         out_wr <= fwd ? wr_mask : '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (fwd && wr_mask[i]) begin
               out_data[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
               out_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH] <= in_ctrl;
            end
         end
      end
   end

`ifdef PKT_DISPATCH_CNT_EN
   logic eop;
   assign eop = (state == ST_BODY) && in_wr && marked;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch_pkt_cnt <= '0;
      end else if (eop) begin
         for (int unsigned i = 0; i < NUM_CH; i++)
            if (tgt_mask[i]) ch_pkt_cnt[i*32 +: 32] <= ch_pkt_cnt[i*32 +: 32] + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pkt_dispatcher.sv
// Directed self-checking bench for pkt_dispatcher (NUM_CH=4): steering table
// plus hand-written packet sequences; counters checked when PKT_DISPATCH_CNT_EN is set.
module tb_pkt_dispatcher;

   localparam int unsigned NCH = 4;
   localparam int unsigned DW  = 64;
   localparam int unsigned CW  = 8;
   localparam int unsigned CHW = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic [DW-1:0]      in_data;
   logic [CW-1:0]      in_ctrl;
   logic               in_wr;
   logic               in_rdy;
   logic [1:0]         mode;
   logic [CHW-1:0]     fixed_sel;
   logic [NCH-1:0]     ch_enable, ch_almfull, ch_stall;
   logic [NCH*DW-1:0]  out_data;
   logic [NCH*CW-1:0]  out_ctrl;
   logic [NCH-1:0]     out_wr;
   logic               busy;
`ifdef PKT_DISPATCH_CNT_EN
   logic [NCH*32-1:0]  ch_pkt_cnt;
`endif

   pkt_dispatcher #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_CH(NCH), .CH_W(CHW)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .in_wr      (in_wr),
      .in_rdy     (in_rdy),
      .mode       (mode),
      .fixed_sel  (fixed_sel),
      .ch_enable  (ch_enable),
      .ch_almfull (ch_almfull),
      .ch_stall   (ch_stall),
      .out_data   (out_data),
      .out_ctrl   (out_ctrl),
      .out_wr     (out_wr),
      .busy       (busy)
`ifdef PKT_DISPATCH_CNT_EN
      ,
      .ch_pkt_cnt (ch_pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [DW-1:0] rxq [NCH][$];
   logic          stall_mon = 1'b0;
   int unsigned   low_cnt   = 0;

   always @(negedge clk) begin
      for (int unsigned i = 0; i < NCH; i++)
         if (out_wr[i]) rxq[i].push_back(out_data[i*DW +: DW]);
      if (stall_mon && busy && !in_rdy) low_cnt++;
   end

   typedef struct {
      logic [1:0]     mode;
      logic [CHW-1:0] sel;
      logic [NCH-1:0] en;
      logic [NCH-1:0] af;
      logic [NCH-1:0] st;
      logic           exp_rdy;
      logic [NCH-1:0] exp_mask;
   } vec_t;

   vec_t vt [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_q();
      for (int unsigned i = 0; i < NCH; i++) rxq[i].delete();
   endtask

   task automatic do_reset();
      in_wr      = 1'b0;
      ch_almfull = '0;
      ch_stall   = '0;
      reset      = 1'b1;
      step();
      step();
      reset = 1'b0;
      clear_q();
   endtask

   // Valid/ready driver: in_wr only raised when in_rdy is seen, starting at edge+2.
   task automatic send_pkt(input int unsigned len, input bit hdr, input logic [DW-1:0] base);
      int unsigned idx = 0;
      int unsigned cyc = 0;
      while (idx < len && cyc < 200) begin
         in_data = base + DW'(idx);
         in_ctrl = (idx == len - 1) ? 8'h01 : ((idx == 0 && hdr) ? 8'hFF : 8'h00);
         in_wr   = in_rdy;
         @(posedge clk);
         if (in_wr) idx++;
         #2;
         cyc++;
      end
      in_wr = 1'b0;
      if (idx < len) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: sent %0d of %0d words", idx, len);
      end
   endtask

   task automatic collect(output logic [NCH-1:0] m, output int unsigned words);
      step();
      m     = '0;
      words = 0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (rxq[i].size() != 0) m[i] = 1'b1;
         words += rxq[i].size();
         rxq[i].delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [NCH-1:0] m;
      logic [NCH-1:0] rr_exp_a [6];
      logic [NCH-1:0] rr_exp_b [6];
      int unsigned    words, errs;
      logic [DW-1:0]  d;

      vt[0]  = '{2'd0, 2'd0, 4'hF, 4'h0, 4'h0, 1'b1, 4'hF};
      vt[1]  = '{2'd0, 2'd0, 4'hF, 4'h2, 4'h0, 1'b0, 4'h0};
      vt[2]  = '{2'd0, 2'd0, 4'h5, 4'h2, 4'h0, 1'b1, 4'h5};
      vt[3]  = '{2'd3, 2'd0, 4'h3, 4'h0, 4'h0, 1'b1, 4'h3};
      vt[4]  = '{2'd1, 2'd0, 4'hF, 4'h0, 4'h0, 1'b1, 4'h1};
      vt[5]  = '{2'd1, 2'd0, 4'hF, 4'h0, 4'h2, 1'b1, 4'h4};
      vt[6]  = '{2'd1, 2'd0, 4'h9, 4'h0, 4'h0, 1'b1, 4'h8};
      vt[7]  = '{2'd1, 2'd0, 4'hF, 4'hF, 4'h0, 1'b0, 4'h0};
      vt[8]  = '{2'd1, 2'd0, 4'hF, 4'h1, 4'h0, 1'b1, 4'h2};
      vt[9]  = '{2'd2, 2'd2, 4'hF, 4'h0, 4'h0, 1'b1, 4'h4};
      vt[10] = '{2'd2, 2'd1, 4'hD, 4'h0, 4'h0, 1'b0, 4'h0};
      vt[11] = '{2'd2, 2'd0, 4'hF, 4'h0, 4'h1, 1'b0, 4'h0};
      vt[12] = '{2'd2, 2'd3, 4'hF, 4'h0, 4'h0, 1'b1, 4'h8};
      vt[13] = '{2'd1, 2'd0, 4'hF, 4'h0, 4'h0, 1'b1, 4'h4};

      rr_exp_a = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
      rr_exp_b = '{4'h1, 4'h4, 4'h8, 4'h1, 4'h4, 4'h8};

      reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0;
      mode = 2'd0; fixed_sel = '0; ch_enable = '1; ch_almfull = '0; ch_stall = '0;
      #1;
      chk("rst_out_wr", 64'(out_wr), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_in_rdy", 64'(in_rdy), 64'h0);
      chk("rst_out_data0", out_data[DW-1:0], 64'h0);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;

      // Steering table: SOP (ctrl 00) then EOP (ctrl 01), checking 1-cycle latency.
      for (int unsigned v = 0; v < 14; v++) begin
         mode = vt[v].mode; fixed_sel = vt[v].sel; ch_enable = vt[v].en;
         ch_almfull = vt[v].af; ch_stall = vt[v].st;
         in_ctrl = 8'h00;
         in_data = 64'hA000 + DW'(v * 2);
         #1;
         chk($sformatf("v%0d_rdy", v), 64'(in_rdy), 64'(vt[v].exp_rdy));
         if (vt[v].exp_rdy) begin
            in_wr = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("v%0d_sop_wr", v), 64'(out_wr), 64'(vt[v].exp_mask));
            chk($sformatf("v%0d_sop_busy", v), 64'(busy), 64'h1);
            for (int unsigned i = 0; i < NCH; i++)
               if (vt[v].exp_mask[i])
                  chk($sformatf("v%0d_data_ch%0d", v, i), out_data[i*DW +: DW], 64'hA000 + 64'(v * 2));
            in_data = 64'hA001 + DW'(v * 2);
            in_ctrl = 8'h01;
            #1;
            chk($sformatf("v%0d_body_rdy", v), 64'(in_rdy), 64'h1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_eop_wr", v), 64'(out_wr), 64'(vt[v].exp_mask));
            chk($sformatf("v%0d_eop_busy", v), 64'(busy), 64'h0);
            in_wr = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle_wr", v), 64'(out_wr), 64'h0);
         end
         @(posedge clk); #2;
      end
      ch_almfull = '0; ch_stall = '0;

      // Broadcast to two channels, 20-word packet FF,00x18,01.
      do_reset();
      mode = 2'd0; ch_enable = 4'b0011;
      send_pkt(20, 1'b1, 64'h1000);
      step();
      chk("bc_cnt_ch0", 64'(rxq[0].size()), 64'd20);
      chk("bc_cnt_ch1", 64'(rxq[1].size()), 64'd20);
      chk("bc_cnt_ch2", 64'(rxq[2].size()), 64'd0);
      errs = 0;
      if (rxq[0].size() == 20 && rxq[1].size() == 20)
         for (int unsigned k = 0; k < 20; k++)
            if (rxq[0][k] !== 64'h1000 + 64'(k) || rxq[1][k] !== rxq[0][k]) errs++;
      chk("bc_data_errs", 64'(errs), 64'd0);

      // Round-robin order, then with channel 1 almost-full after the first packet.
      do_reset();
      mode = 2'd1; ch_enable = 4'hF;
      for (int unsigned p = 0; p < 6; p++) begin
         send_pkt(3, 1'b1, 64'h2000 + DW'(p * 16));
         collect(m, words);
         chk($sformatf("rr_a_pkt%0d", p), 64'(m), 64'(rr_exp_a[p]));
      end
      do_reset();
      mode = 2'd1; ch_enable = 4'hF;
      for (int unsigned p = 0; p < 6; p++) begin
         if (p == 1) ch_almfull = 4'b0010;
         send_pkt(3, 1'b1, 64'h2800 + DW'(p * 16));
         collect(m, words);
         chk($sformatf("rr_b_pkt%0d", p), 64'(m), 64'(rr_exp_b[p]));
      end
      ch_almfull = '0;

      // Fixed channel 3, stall pulsed for 5 cycles mid-body.
      do_reset();
      mode = 2'd2; fixed_sel = 2'd3; ch_enable = 4'hF;
      low_cnt = 0;
      stall_mon = 1'b1;
      fork
         send_pkt(20, 1'b0, 64'h3000);
         begin
            repeat (8) @(posedge clk);
            #1 ch_stall[3] = 1'b1;
            repeat (5) @(posedge clk);
            #1 ch_stall[3] = 1'b0;
         end
      join
      stall_mon = 1'b0;
      step();
      chk("stall_low_cycles", 64'(low_cnt), 64'd5);
      chk("stall_cnt_ch3", 64'(rxq[3].size()), 64'd20);
      chk("stall_cnt_ch0", 64'(rxq[0].size()), 64'd0);
      errs = 0;
      if (rxq[3].size() == 20)
         for (int unsigned k = 0; k < 20; k++)
            if (rxq[3][k] !== 64'h3000 + 64'(k)) errs++;
      chk("stall_data_errs", 64'(errs), 64'd0);

      // No channel enabled: nothing may be offered or written.
      do_reset();
      mode = 2'd0; ch_enable = 4'h0;
      errs = 0;
      for (int unsigned c = 0; c < 100; c++) begin
         step();
         if (in_rdy !== 1'b0 || out_wr !== '0 || busy !== 1'b0) errs++;
      end
      chk("disabled_violations", 64'(errs), 64'd0);
      ch_enable = 4'b0100;
      send_pkt(3, 1'b1, 64'h4000);
      collect(m, words);
      chk("en2_mask", 64'(m), 64'h4);
      chk("en2_words", 64'(words), 64'd3);

      // Reset asserted while word 7 of a round-robin packet is presented.
      do_reset();
      mode = 2'd1; ch_enable = 4'hF;
      for (int unsigned w = 0; w < 6; w++) begin
         in_data = 64'h5000 + DW'(w);
         in_ctrl = (w == 0) ? 8'hFF : 8'h00;
         in_wr = 1'b1;
         step();
      end
      chk("midrst_pre_wr", 64'(out_wr), 64'h1);
      chk("midrst_pre_busy", 64'(busy), 64'h1);
      in_data = 64'h5006;
      #1 reset = 1'b1;
      #1;
      chk("midrst_out_wr", 64'(out_wr), 64'h0);
      chk("midrst_busy", 64'(busy), 64'h0);
      chk("midrst_in_rdy", 64'(in_rdy), 64'h0);
      in_wr = 1'b0;
      step();
      reset = 1'b0;
      clear_q();
      send_pkt(3, 1'b1, 64'h5100);
      collect(m, words);
      chk("midrst_next_mask", 64'(m), 64'h1);
      chk("midrst_next_words", 64'(words), 64'd3);

`ifdef PKT_DISPATCH_CNT_EN
      do_reset();
      mode = 2'd1; ch_enable = 4'hF;
      for (int unsigned p = 0; p < 5; p++) send_pkt(3, 1'b1, 64'h6000 + DW'(p * 16));
      step();
      chk("cnt_ch0", 64'(ch_pkt_cnt[31:0]), 64'd2);
      chk("cnt_ch1", 64'(ch_pkt_cnt[63:32]), 64'd1);
      chk("cnt_ch2", 64'(ch_pkt_cnt[95:64]), 64'd1);
      chk("cnt_ch3", 64'(ch_pkt_cnt[127:96]), 64'd1);
`endif

      d = '0;
      in_data = d;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pkt_dispatcher.md
Name: pkt_dispatcher

Overview:
Parametrised N-channel packet dispatcher placed between the encrypt/decrypt accelerator output and the per-core fifo_sram instances. It generalises the current fixed two-core fan-out, where every core receives every word, to NUM_CH channels with three modes: broadcast, round-robin, and fixed-select. Whole packets are steered, never split. Backpressure is per channel, taken from each fifo's almfull and stall.

Parameters:
DATA_WIDTH, 64, data word width
CTRL_WIDTH, DATA_WIDTH/8, ctrl width
NUM_CH, 2, number of core channels (2..8)
CH_W, $clog2(NUM_CH), channel index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_data  in  DATA_WIDTH  input word
in_ctrl  in  CTRL_WIDTH  input ctrl
in_wr  in  1  input word valid
in_rdy  out  1  dispatcher can accept a word this cycle
mode  in  2  0=broadcast, 1=round-robin, 2=fixed, 3=reserved (treated as broadcast)
fixed_sel  in  CH_W  target channel in fixed mode
ch_enable  in  NUM_CH  per-channel enable
ch_almfull  in  NUM_CH  per-channel fifo almost-full
ch_stall  in  NUM_CH  per-channel core stall
out_data  out  NUM_CH*DATA_WIDTH  per-channel data (channel i at slice i)
out_ctrl  out  NUM_CH*CTRL_WIDTH  per-channel ctrl
out_wr  out  NUM_CH  per-channel write strobe
busy  out  1  high while a packet is in progress

Behaviour:
- Reset (async, active-high): all outputs 0, FSM in IDLE, round-robin pointer = NUM_CH-1 (so the first RR pick is channel 0), target mask 0.
- ch_ready[i] = ch_enable[i] & ~ch_almfull[i] & ~ch_stall[i].
- FSM states: IDLE, HDR, BODY.
  - IDLE: compute the candidate mask from mode.
    - Broadcast: all enabled channels; requires every enabled channel ready.
    - RR: the first ready channel searching upward (modulo NUM_CH) from pointer+1.
    - Fixed: fixed_sel; requires ch_enable[fixed_sel] and ch_ready[fixed_sel]. fixed_sel >= NUM_CH means no candidate.
    - No candidate (including ch_enable == 0): in_rdy = 0.
  - IDLE, accepted word: latch the target mask and go to HDR. In RR mode the pointer updates to the chosen channel.
  - HDR: words with ctrl != 0 are module headers. The first word with ctrl == 0 moves the FSM to BODY.
  - BODY: a word with ctrl != 0 is EOP. The FSM returns to IDLE on the cycle after the EOP is accepted.
  - A word with ctrl == 0 accepted in IDLE goes straight to BODY (headerless packet).
- In HDR and BODY, in_rdy = AND of ch_ready over the latched target mask. Mode, fixed_sel and ch_enable changes mid-packet take effect only at the next SOP.
- Accept = in_wr & in_rdy. Latency: exactly 1 cycle. out_wr[i] is registered high on the cycle after accept for each i in the target mask; data and ctrl are registered alongside. out_data/out_ctrl hold their previous value when out_wr is low.
- in_wr while in_rdy = 0: the word is forwarded anyway, on the same 1-cycle path (the fifo almfull margin absorbs it), and FSM tracking proceeds normally. Upstream is not expected to do this.
- Simultaneous EOP and SOP: no SOP is accepted in the EOP+1 cycle unless the FSM has already returned to IDLE. Minimum gap is therefore 0 cycles between an EOP accept and the next SOP accept in the following cycle.
- Channel disabled mid-packet: still receives the rest of the packet (the latched mask wins).
- busy = (state != IDLE).

Optional Feature:
PKT_DISPATCH_CNT_EN: when defined, the block adds output ch_pkt_cnt[NUM_CH*32], one 32-bit wrapping counter per channel. The counter increments on each accepted EOP for every channel in the target mask. Counters clear on reset only and wrap from 0xFFFFFFFF to 0. When the macro is undefined, the port and counters are absent.

Decomposition:
- Package pkt_dispatch_pkg holds:
  - mode constants MODE_BCAST=2'd0, MODE_RR=2'd1, MODE_FIXED=2'd2;
  - the FSM state enum;
  - the ctrl header/EOP decode function.
- One sub-module, rr_pick: inputs a ready mask and a pointer, outputs a one-hot grant and a valid flag. It is purely combinational and reused by the fifo readback merge.

Test Plan:
- NUM_CH=2, mode 0, all ready; send a 20-word packet (ctrl FF, 00×18, 01) -> out_wr[0] and out_wr[1] each pulse 20 times, starting 1 cycle after the first accept, with identical data on both.
- NUM_CH=4, mode 1, 6 packets -> packets land on channels 0,1,2,3,0,1. With ch_almfull[1]=1 before the second SOP, the order becomes 0,2,3,0,2,3.
- Mode 2, fixed_sel=3, ch_stall[3] pulsed high for 5 cycles mid-body -> in_rdy low for exactly those 5 cycles; no word lost or duplicated on channel 3.
- ch_enable=0 -> in_rdy stays 0 and no out_wr for 100 cycles. Set ch_enable=4'b0100 in mode 0 -> only channel 2 receives the packet.
- Assert reset during word 7 of a packet -> all out_wr=0 and busy=0 immediately; the next packet starts cleanly in IDLE on channel 0 (RR).
- PKT_DISPATCH_CNT_EN defined, mode 1, NUM_CH=2, 5 packets -> ch_pkt_cnt = {2, 3} (channel 1 = 2, channel 0 = 3).
